// File: rtl/jt10_pkg.sv
// Shared constants and types for the ADPCM-A channel scheduler.
// Covers the channel count, the slot width and the key-register bit layout.
package jt10_pkg;

  localparam int NUM_CH   = 6;
  localparam int SLOT_W   = 3;
  localparam int KOFF_BIT = 7;
  localparam int MASK_MSB = 5;

  typedef logic [NUM_CH-1:0] chmask_t;
  typedef logic [SLOT_W-1:0] slot_t;

  function automatic chmask_t slot_bit(slot_t s);
    return chmask_t'(1) << s;
  endfunction

endpackage

// File: rtl/jt10_adpcma_pend.sv
// Per-channel pending key-on/key-off registers.
// Ports: rst_i/clk_i, cen_i + s_i consume slot s_i, wr_i/koff_i/mask_i post a write,
// kon_o/koff_o expose the pending masks.
module jt10_adpcma_pend
  import jt10_pkg::*;
(
  input  logic              rst_i,
  input  logic              clk_i,
  input  logic              cen_i,
  input  logic [SLOT_W-1:0] s_i,
  input  logic              wr_i,
  input  logic              koff_i,
  input  logic [NUM_CH-1:0] mask_i,
  output logic [NUM_CH-1:0] kon_o,
  output logic [NUM_CH-1:0] koff_o
);

  chmask_t kon_q, kon_d;
  chmask_t koff_q, koff_d;

  // The served slot is cleared first, so a write landing on the same clk
  // survives and is applied on the next visit to that channel.
  always_comb begin
    kon_d  = kon_q;
    koff_d = koff_q;
    if (cen_i) begin
      kon_d  = kon_d & ~slot_bit(s_i);
      koff_d = koff_d & ~slot_bit(s_i);
    end
    if (wr_i) begin
      if (koff_i) begin
        koff_d = koff_d | mask_i;
        kon_d  = kon_d & ~mask_i;
      end else begin
        kon_d  = kon_d | mask_i;
        koff_d = koff_d & ~mask_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kon_q  <= '0;
      koff_q <= '0;
    end else begin
      kon_q  <= kon_d;
      koff_q <= koff_d;
    end
  end

  assign kon_o  = kon_q;
  assign koff_o = koff_q;

endmodule

// File: rtl/jt10_adpcma_sched.sv
// Six-slot channel scheduler for the shared ADPCM-A decoder.
// Ports: cen advances the slot; wr_kon/kon_din post key commands; eos ends a
// sample; slot/ch_kon/ch_koff/frame pulse per slot; active/flags/irq report state.
module jt10_adpcma_sched
  import jt10_pkg::*;
(
  input  logic              rst,
  input  logic              clk,
  input  logic              cen,
  input  logic              wr_kon,
  input  logic [7:0]        kon_din,
  input  logic              eos,
  input  logic [NUM_CH-1:0] flag_clr,
  input  logic [NUM_CH-1:0] flag_mask,
  output logic [SLOT_W-1:0] slot,
  output logic              ch_kon,
  output logic              ch_koff,
  output logic              frame,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] flags,
  output logic              irq
);

  slot_t   cnt_q, cnt_d;
  slot_t   slot_q, slot_d;
  logic    kon_q, kon_d;
  logic    koff_q, koff_d;
  logic    frame_q, frame_d;
  chmask_t active_q, active_d;
  chmask_t flags_q, flags_d;
  chmask_t flag_set;
  logic    irq_q, irq_d;
  chmask_t kon_pend, koff_pend;
  chmask_t sbit;
  logic    unused_din6;

  assign unused_din6 = kon_din[6];
  assign sbit = slot_bit(cnt_q);

  jt10_adpcma_pend u_pend (
    .rst_i  (rst),
    .clk_i  (clk),
    .cen_i  (cen),
    .s_i    (cnt_q),
    .wr_i   (wr_kon),
    .koff_i (kon_din[KOFF_BIT]),
    .mask_i (kon_din[MASK_MSB:0]),
    .kon_o  (kon_pend),
    .koff_o (koff_pend)
  );

  always_comb begin
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    kon_d    = 1'b0;
    koff_d   = 1'b0;
    frame_d  = 1'b0;
    active_d = active_q;
    flag_set = '0;
    if (cen) begin
      cnt_d   = (cnt_q == SLOT_W'(NUM_CH-1)) ? '0 : cnt_q + 1'b1;
      slot_d  = cnt_q;
      kon_d   = |(kon_pend & sbit);
      koff_d  = |(koff_pend & sbit);
      frame_d = (cnt_q == '0);
      // eos only counts for a playing channel; a key command in the same
      // slot still decides the final active state.
      if (eos && |(active_q & sbit)) begin
        flag_set = sbit;
        active_d = active_d & ~sbit;
      end
      if (kon_d)
        active_d = active_d | sbit;
      else if (koff_d)
        active_d = active_d & ~sbit;
    end
    flags_d = (flags_q & ~flag_clr) | flag_set;
    irq_d   = |(flags_q & ~flag_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      slot_q   <= '0;
      kon_q    <= 1'b0;
      koff_q   <= 1'b0;
      frame_q  <= 1'b0;
      active_q <= '0;
      flags_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      kon_q    <= kon_d;
      koff_q   <= koff_d;
      frame_q  <= frame_d;
      active_q <= active_d;
      flags_q  <= flags_d;
      irq_q    <= irq_d;
    end
  end

  assign slot    = slot_q;
  assign ch_kon  = kon_q;
  assign ch_koff = koff_q;
  assign frame   = frame_q;
  assign active  = active_q;
  assign flags   = flags_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_jt10_adpcma_sched.sv
// Directed testbench for jt10_adpcma_sched.
// Linear stimulus with hand-computed expectations checked by immediate assertions.
module tb_jt10_adpcma_sched;

  logic       rst = 1'b1;
  logic       clk = 1'b0;
  logic       cen = 1'b0;
  logic       wr_kon = 1'b0;
  logic [7:0] kon_din = 8'h00;
  logic       eos = 1'b0;
  logic [5:0] flag_clr = 6'h00;
  logic [5:0] flag_mask = 6'h00;
  logic [2:0] slot;
  logic       ch_kon, ch_koff, frame, irq;
  logic [5:0] active, flags;

  int n_checks = 0;
  int n_errors = 0;
  int frames;
  int exp_slot;

  jt10_adpcma_sched dut (
    .rst       (rst),
    .clk       (clk),
    .cen       (cen),
    .wr_kon    (wr_kon),
    .kon_din   (kon_din),
    .eos       (eos),
    .flag_clr  (flag_clr),
    .flag_mask (flag_mask),
    .slot      (slot),
    .ch_kon    (ch_kon),
    .ch_koff   (ch_koff),
    .frame     (frame),
    .active    (active),
    .flags     (flags),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clk with cen high, then inputs return idle
  task automatic pulse(input logic e);
    cen = 1'b1;
    eos = e;
    tick();
    cen = 1'b0;
    eos = 1'b0;
  endtask

  task automatic write(input logic [7:0] d);
    wr_kon  = 1'b1;
    kon_din = d;
    tick();
    wr_kon  = 1'b0;
    kon_din = 8'h00;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_slot", {5'd0, slot}, 8'h00);
    chk("rst_active", {2'd0, active}, 8'h00);
    chk("rst_flags", {2'd0, flags}, 8'h00);
    chk("rst_pulses", {4'd0, ch_kon, ch_koff, frame, irq}, 8'h00);
    rst = 1'b0;
    tick();

    // 12 bare slots: counter wraps twice, two frame pulses
    frames = 0;
    for (int i = 0; i < 12; i++) begin
      pulse(1'b0);
      chk("cyc_slot", {5'd0, slot}, 8'(i % 6));
      chk("cyc_frame", {7'd0, frame}, {7'd0, (i % 6) == 0});
      chk("cyc_keys", {6'd0, ch_kon, ch_koff}, 8'h00);
      if (frame) frames++;
      tick();
      chk("cyc_idle", {6'd0, frame, ch_kon}, 8'h00);
    end
    chk("frame_count", 8'(frames), 8'd2);

    // key-on mask 05 posted with counter at 3
    for (int i = 0; i < 3; i++) pulse(1'b0);
    write(8'h05);
    for (int i = 0; i < 6; i++) begin
      exp_slot = (3 + i) % 6;
      pulse(1'b0);
      chk("kon_slot", {5'd0, slot}, 8'(exp_slot));
      chk("kon_pulse", {7'd0, ch_kon}, {7'd0, exp_slot == 0 || exp_slot == 2});
    end
    chk("kon_active", {2'd0, active}, 8'h05);

    // counter at 3: eos on channel 2
    for (int i = 0; i < 5; i++) pulse(1'b0);
    pulse(1'b1);
    chk("eos_active", {2'd0, active}, 8'h01);
    chk("eos_flags", {2'd0, flags}, 8'h04);
    chk("eos_irq_lag", {7'd0, irq}, 8'h00);
    tick();
    chk("eos_irq", {7'd0, irq}, 8'h01);
    flag_clr = 6'h04;
    tick();
    flag_clr = 6'h00;
    chk("clr_flags", {2'd0, flags}, 8'h00);
    tick();
    chk("clr_irq", {7'd0, irq}, 8'h00);

    // key-on then key-off for ch0 before it is served (counter at 3)
    write(8'h01);
    write(8'h81);
    for (int i = 0; i < 3; i++) pulse(1'b0);
    pulse(1'b0);
    chk("koff_slot", {5'd0, slot}, 8'h00);
    chk("koff_pulse", {6'd0, ch_kon, ch_koff}, 8'h01);
    chk("koff_active", {2'd0, active}, 8'h00);

    // counter at 1: pending ch1 plus a colliding write on the service clk
    write(8'h02);
    wr_kon  = 1'b1;
    kon_din = 8'h02;
    pulse(1'b0);
    wr_kon  = 1'b0;
    kon_din = 8'h00;
    chk("coll_slot", {5'd0, slot}, 8'h01);
    chk("coll_kon1", {7'd0, ch_kon}, 8'h01);
    chk("coll_active", {2'd0, active}, 8'h02);
    for (int i = 0; i < 5; i++) begin
      pulse(1'b0);
      chk("coll_quiet", {7'd0, ch_kon}, 8'h00);
    end
    pulse(1'b0);
    chk("coll_kon2", {6'd0, ch_kon, ch_koff}, 8'h02);

    // counter at 2: eos and flag_clr together on ch1
    for (int i = 0; i < 5; i++) pulse(1'b0);
    flag_clr = 6'h02;
    pulse(1'b1);
    flag_clr = 6'h00;
    chk("setclr_flags", {2'd0, flags}, 8'h02);
    chk("setclr_active", {2'd0, active}, 8'h00);
    tick();
    chk("setclr_irq", {7'd0, irq}, 8'h01);

    // masked irq
    flag_mask = 6'h02;
    tick();
    tick();
    chk("mask_irq", {7'd0, irq}, 8'h00);
    flag_mask = 6'h00;

    // fill all flags, then leave 3F pending and reset mid-frame
    write(8'h3F);
    for (int i = 0; i < 6; i++) pulse(1'b0);
    chk("all_active", {2'd0, active}, 8'h3F);
    for (int i = 0; i < 6; i++) pulse(1'b1);
    chk("all_flags", {2'd0, flags}, 8'h3F);
    chk("all_idle", {2'd0, active}, 8'h00);
    write(8'h3F);
    pulse(1'b0);
    pulse(1'b0);
    chk("pre_rst_irq", {7'd0, irq}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_slot", {5'd0, slot}, 8'h00);
    chk("arst_flags", {2'd0, flags}, 8'h00);
    chk("arst_active", {2'd0, active}, 8'h00);
    chk("arst_pulses", {4'd0, ch_kon, ch_koff, frame, irq}, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      pulse(1'b0);
      chk("post_rst_slot", {5'd0, slot}, 8'(i));
      chk("post_rst_kon", {6'd0, ch_kon, ch_koff}, 8'h00);
    end
    chk("post_rst_active", {2'd0, active}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
